word_uart_tx: RTL and testbench

- Transmit-side counterpart of the UART program loader: accepts 32-bit words from the core/memory hub and emits them as 4 bytes through the shared UartTx (tx_start/sdata/tx_busy handshake).
- Buffers up to FIFO_DEPTH words so the core never stalls on a single byte time.
- Sits between MemoryControllerHub and the top-level tx_start/sdata mux.

---
 rtl/word_uart_pkg.sv | 16 +
 rtl/word_fifo.sv | 51 +++++
 rtl/word_uart_tx.sv | 114 +++++++++++
 tb/tb_word_uart_tx.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_uart_pkg.sv
// rtl/word_uart_pkg.sv - shared constants and FSM state type for the word UART transmitter
// Contents: BYTES_PER_WORD, BYTE_IDX_W, state_e (ST_IDLE, ST_LOAD, ST_SEND, ST_GUARD).
package word_uart_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

   // Fixed encoding so state values stay stable for anything decoding them by number.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SEND  = 2'd2,
      ST_GUARD = 2'd3
   } state_e;

endpackage

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - parameterised synchronous FIFO with full/empty/count
// Ports: clock, reset (sync, active-high), push/push_data, pop/pop_data (head, combinational),
//        full, empty, count (entries held, $clog2(DEPTH)+1 bits).
module word_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 32
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             push_en;
   logic             pop_en;

   // Overflow/underflow requests are dropped rather than corrupting the pointers.
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;

   // Pointers carry one extra wrap bit: equal addresses with differing wrap bits means full.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count    = wr_ptr - rd_ptr;
   assign pop_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop_en)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (push_en) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/word_uart_tx.sv
// rtl/word_uart_tx.sv - buffers 32-bit words and feeds them bytewise to a shared UartTx
// Ports: clock, reset (sync, active-high); word_valid/word_data/word_ready (word input);
//        tx_busy (from UartTx), tx_start/sdata (to UartTx); fifo_count, idle (status).
// Optional: WORD_UART_TX_STATS_EN adds output words_sent[31:0] (completed words, wraps).
module word_uart_tx
   import word_uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter bit LSB_FIRST  = 1'b1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          word_valid,
   input  logic [31:0]                   word_data,
   output logic                          word_ready,
   input  logic                          tx_busy,
   output logic                          tx_start,
   output logic [7:0]                    sdata,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          idle
`ifdef WORD_UART_TX_STATS_EN
   ,
   output logic [31:0]                   words_sent
`endif
);

   state_e                state;
   logic [31:0]           shreg;
   logic [BYTE_IDX_W-1:0] byte_idx;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [31:0]           fifo_head;
   logic                  push;
   logic                  pop;
   logic                  last_byte;
   logic [7:0]            cur_byte;

   assign word_ready = !fifo_full;
   assign push       = word_valid && !fifo_full;
   // LOAD is only entered with a non-empty FIFO, so the pop never underflows.
   assign pop        = (state == ST_LOAD);
   assign idle       = fifo_empty && (state == ST_IDLE);
   assign last_byte  = (byte_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));
   assign cur_byte   = LSB_FIRST ? shreg[7:0] : shreg[31:24];

   word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (word_data),
      .pop       (pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         shreg    <= '0;
         byte_idx <= '0;
         tx_start <= 1'b0;
         sdata    <= '0;
      end else begin
         tx_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) state <= ST_LOAD;
            end
            ST_LOAD: begin
               shreg    <= fifo_head;
               byte_idx <= '0;
               state    <= ST_SEND;
            end
            ST_SEND: begin
               if (!tx_busy) begin
                  tx_start <= 1'b1;
                  sdata    <= cur_byte;
                  state    <= ST_GUARD;
               end
            end
            ST_GUARD: begin
               // UartTx only raises busy on the edge that samples tx_start, so busy
               // is not trustworthy in this cycle; never look at it here.
               if (!last_byte) begin
                  byte_idx <= byte_idx + BYTE_IDX_W'(1);
                  shreg    <= LSB_FIRST ? (shreg >> 8) : (shreg << 8);
                  state    <= ST_SEND;
               end else if (!fifo_empty) begin
                  state <= ST_LOAD;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef WORD_UART_TX_STATS_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         words_sent <= '0;
      end else if (state == ST_GUARD && last_byte) begin
         words_sent <= words_sent + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_word_uart_tx.sv
// tb/tb_word_uart_tx.sv - self-checking bench for word_uart_tx (LSB-first and MSB-first instances)
module tb_word_uart_tx;

   localparam int DEPTH    = 16;
   localparam int BUSY_LEN = 10;

   logic        clock = 1'b0;
   logic        reset;
   logic        word_valid;
   logic [31:0] word_data;
   logic        hold_busy;
   logic        mon_clr;

   logic        word_ready_a, tx_start_a, idle_a, tx_busy_a;
   logic [7:0]  sdata_a;
   logic [4:0]  fifo_count_a;
   logic        word_ready_b, tx_start_b, idle_b, tx_busy_b;
   logic [7:0]  sdata_b;
   logic [4:0]  fifo_count_b;
`ifdef WORD_UART_TX_STATS_EN
   logic [31:0] words_sent_a, words_sent_b;
`endif

   int busy_cnt_a = 0;
   int busy_cnt_b = 0;
   logic [7:0] cap_a [$];
   logic [7:0] cap_b [$];
   int   b2b_a = 0;
   int   b2b_b = 0;
   logic prev_a = 1'b0;
   logic prev_b = 1'b0;
   int   max_count = 0;
   bit   saw_not_ready = 1'b0;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   word_uart_tx #(.FIFO_DEPTH(DEPTH), .LSB_FIRST(1'b1)) dut_a (
      .clock      (clock),
      .reset      (reset),
      .word_valid (word_valid),
      .word_data  (word_data),
      .word_ready (word_ready_a),
      .tx_busy    (tx_busy_a),
      .tx_start   (tx_start_a),
      .sdata      (sdata_a),
      .fifo_count (fifo_count_a),
      .idle       (idle_a)
`ifdef WORD_UART_TX_STATS_EN
      ,
      .words_sent (words_sent_a)
`endif
   );

   word_uart_tx #(.FIFO_DEPTH(DEPTH), .LSB_FIRST(1'b0)) dut_b (
      .clock      (clock),
      .reset      (reset),
      .word_valid (word_valid),
      .word_data  (word_data),
      .word_ready (word_ready_b),
      .tx_busy    (tx_busy_b),
      .tx_start   (tx_start_b),
      .sdata      (sdata_b),
      .fifo_count (fifo_count_b),
      .idle       (idle_b)
`ifdef WORD_UART_TX_STATS_EN
      ,
      .words_sent (words_sent_b)
`endif
   );

   // UartTx models: busy rises on the edge that samples tx_start and stays up BUSY_LEN cycles.
   assign tx_busy_a = hold_busy | (busy_cnt_a != 0);
   assign tx_busy_b = hold_busy | (busy_cnt_b != 0);

   always @(posedge clock) begin
      if (tx_start_a) begin
         cap_a.push_back(sdata_a);
         busy_cnt_a <= BUSY_LEN;
      end else if (busy_cnt_a != 0) begin
         busy_cnt_a <= busy_cnt_a - 1;
      end
      if (tx_start_a && prev_a) b2b_a <= b2b_a + 1;
      prev_a <= tx_start_a;

      if (mon_clr) begin
         max_count     <= 0;
         saw_not_ready <= 1'b0;
      end else begin
         if (int'(fifo_count_a) > max_count) max_count <= int'(fifo_count_a);
         if (!word_ready_a) saw_not_ready <= 1'b1;
      end
   end

   always @(posedge clock) begin
      if (tx_start_b) begin
         cap_b.push_back(sdata_b);
         busy_cnt_b <= BUSY_LEN;
      end else if (busy_cnt_b != 0) begin
         busy_cnt_b <= busy_cnt_b - 1;
      end
      if (tx_start_b && prev_b) b2b_b <= b2b_b + 1;
      prev_b <= tx_start_b;
   end

   typedef struct {
      logic [31:0] word;
      logic [31:0] lsb_seq;   // bytes in send order, first byte in [31:24]
      logic [31:0] msb_seq;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_word(input logic [31:0] w);
      int  n;
      bit  done;
      n    = 0;
      done = 1'b0;
      word_valid = 1'b1;
      word_data  = w;
      while (!done && n < 2000) begin
         done = word_ready_a;
         tick();
         n++;
      end
      word_valid = 1'b0;
      if (!done) check("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (!(idle_a && idle_b && busy_cnt_a == 0 && busy_cnt_b == 0) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) check("idle_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      vec_t vecs [5];
      int   base_a, base_b, n, bad_a, bad_b;
      logic [31:0] act;

      vecs[0] = '{word: 32'h11223344, lsb_seq: 32'h44332211, msb_seq: 32'h11223344};
      vecs[1] = '{word: 32'hA5B6C7D8, lsb_seq: 32'hD8C7B6A5, msb_seq: 32'hA5B6C7D8};
      vecs[2] = '{word: 32'h80000001, lsb_seq: 32'h01000080, msb_seq: 32'h80000001};
      vecs[3] = '{word: 32'h00FF00FF, lsb_seq: 32'hFF00FF00, msb_seq: 32'h00FF00FF};
      vecs[4] = '{word: 32'hDEADBEEF, lsb_seq: 32'hEFBEADDE, msb_seq: 32'hDEADBEEF};

      reset      = 1'b1;
      word_valid = 1'b0;
      word_data  = '0;
      hold_busy  = 1'b0;
      mon_clr    = 1'b0;
      tick();
      tick();
      check("rst_tx_start", {31'd0, tx_start_a}, 32'd0);
      check("rst_sdata", {24'd0, sdata_a}, 32'd0);
      check("rst_fifo_count", {27'd0, fifo_count_a}, 32'd0);
      check("rst_word_ready", {31'd0, word_ready_a}, 32'd1);
      check("rst_idle", {31'd0, idle_a}, 32'd1);
      reset = 1'b0;
      tick();

      // Single-word vectors through both byte orders.
      for (int i = 0; i < 5; i++) begin
         base_a = cap_a.size();
         base_b = cap_b.size();
         push_word(vecs[i].word);
         if (i == 0) begin
            check("not_idle_after_push", {31'd0, idle_a}, 32'd0);
            n = 0;
            while (!tx_start_a && n < 20) begin
               tick();
               n++;
            end
            check("first_byte_latency", n, 32'd3);
         end
         wait_idle(500);
         check("vec_count_lsb", cap_a.size() - base_a, 32'd4);
         check("vec_count_msb", cap_b.size() - base_b, 32'd4);
         if (cap_a.size() >= base_a + 4) begin
            act = {cap_a[base_a], cap_a[base_a+1], cap_a[base_a+2], cap_a[base_a+3]};
            check("vec_bytes_lsb", act, vecs[i].lsb_seq);
         end
         if (cap_b.size() >= base_b + 4) begin
            act = {cap_b[base_b], cap_b[base_b+1], cap_b[base_b+2], cap_b[base_b+3]};
            check("vec_bytes_msb", act, vecs[i].msb_seq);
         end
         check("sdata_hold_lsb", {24'd0, sdata_a}, {24'd0, vecs[i].lsb_seq[7:0]});
         check("idle_after_vec", {31'd0, idle_a}, 32'd1);
      end

      // UartTx held busy while a word waits in SEND.
      base_a = cap_a.size();
      hold_busy = 1'b1;
      push_word(32'hCAFEF00D);
      repeat (50) tick();
      check("busy_hold_no_start", cap_a.size() - base_a, 32'd0);
      check("busy_hold_tx_start", {31'd0, tx_start_a}, 32'd0);
      hold_busy = 1'b0;
      tick();
      check("busy_release_start", {31'd0, tx_start_a}, 32'd1);
      check("busy_release_sdata_lsb", {24'd0, sdata_a}, 32'h0D);
      check("busy_release_sdata_msb", {24'd0, sdata_b}, 32'hCA);
      wait_idle(500);
      check("busy_word_bytes", cap_a.size() - base_a, 32'd4);

      // 17 words back to back into a 16-deep FIFO.
      mon_clr = 1'b1;
      tick();
      mon_clr = 1'b0;
      base_a = cap_a.size();
      base_b = cap_b.size();
      for (int w = 0; w < 17; w++) begin
         push_word({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
      end
      wait_idle(3000);
      check("burst_saw_not_ready", {31'd0, saw_not_ready}, 32'd1);
      check("burst_max_count", max_count, 32'd16);
      check("burst_count_lsb", cap_a.size() - base_a, 32'd68);
      check("burst_count_msb", cap_b.size() - base_b, 32'd68);
      bad_a = 0;
      bad_b = 0;
      for (int j = 0; j < 68; j++) begin
         if (base_a + j < cap_a.size() && cap_a[base_a+j] != 8'(j)) bad_a++;
         if (base_b + j < cap_b.size() && cap_b[base_b+j] != 8'(4*(j/4) + 3 - (j%4))) bad_b++;
      end
      check("burst_order_lsb", bad_a, 32'd0);
      check("burst_order_msb", bad_b, 32'd0);

      // Reset while byte 2 of the first word is in flight with 3 words queued.
      base_a = cap_a.size();
      push_word(32'h10203040);
      push_word(32'h50607080);
      push_word(32'h90A0B0C0);
      push_word(32'hD0E0F000);
      n = 0;
      while (cap_a.size() < base_a + 3 && n < 500) begin
         tick();
         n++;
      end
      check("midreset_reached_byte2", cap_a.size() - base_a, 32'd3);
      check("midreset_queued", {27'd0, fifo_count_a}, 32'd3);
      reset = 1'b1;
      tick();
      check("midreset_tx_start", {31'd0, tx_start_a}, 32'd0);
      check("midreset_fifo_count", {27'd0, fifo_count_a}, 32'd0);
      check("midreset_idle", {31'd0, idle_a}, 32'd1);
      check("midreset_word_ready", {31'd0, word_ready_a}, 32'd1);
`ifdef WORD_UART_TX_STATS_EN
      check("stats_after_reset", words_sent_a, 32'd0);
`endif
      reset = 1'b0;
      repeat (100) tick();
      check("midreset_no_more_bytes", cap_a.size() - base_a, 32'd3);
      wait_idle(500);

`ifdef WORD_UART_TX_STATS_EN
      for (int w = 0; w < 5; w++) push_word(32'h01010101 * w);
      wait_idle(1500);
      check("stats_words_sent_lsb", words_sent_a, 32'd5);
      check("stats_words_sent_msb", words_sent_b, 32'd5);
      reset = 1'b1;
      tick();
      check("stats_cleared", words_sent_a, 32'd0);
      reset = 1'b0;
      tick();
`endif

      check("no_b2b_start_lsb", b2b_a, 32'd0);
      check("no_b2b_start_msb", b2b_b, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
